// File: rtl/dsm_pkg.sv
// Shared constants, types and saturation helper for the
// delta-sigma bitstream transmitter.
package dsm_pkg;

   localparam int WIDTH    = 12;
   localparam int OSR      = 512;
   localparam int CNT_W    = $clog2(OSR);
   localparam int ACC_W    = 16;
   localparam int EXT_W    = ACC_W + 2;
   localparam int MIDSCALE = 1 << (WIDTH - 1);

   typedef logic [WIDTH-1:0]        sample_t;
   typedef logic signed [ACC_W-1:0] acc_t;
   typedef logic signed [EXT_W-1:0] ext_t;

   function automatic acc_t sat_acc(input ext_t v);
      ext_t hi;
      ext_t lo;
      hi = ext_t'((2 ** (ACC_W - 1)) - 1);
      lo = -ext_t'(2 ** (ACC_W - 1));
      if (v > hi)
         return acc_t'(hi);
      else if (v < lo)
         return acc_t'(lo);
      else
         return acc_t'(v);
   endfunction

endpackage

// File: rtl/dsm_bitstream_tx_mod2.sv
// Second-order delta-sigma core: two saturating integrators
// with 1-bit feedback into both stages.
module dsm_mod2_core
   import dsm_pkg::*;
(
   input  logic    clk,
   input  logic    rst_n,
   input  sample_t active_i,
   output logic    bit_o
);

   acc_t i1_q, i1_d;
   acc_t i2_q, i2_d;
   logic bit_q, bit_d;
   ext_t u, fb, s1, s2;

   always_comb begin
      u    = ext_t'($signed({1'b0, active_i})) - ext_t'(MIDSCALE);
      fb   = bit_q ? ext_t'(MIDSCALE) : -ext_t'(MIDSCALE);
      s1   = ext_t'(i1_q) + u - fb;
      i1_d = sat_acc(s1);
      // second stage sees the freshly updated first integrator
      s2   = ext_t'(i2_q) + ext_t'(i1_d) - fb;
      i2_d = sat_acc(s2);
      bit_d = ~i2_d[ACC_W-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i1_q  <= '0;
         i2_q  <= '0;
         bit_q <= 1'b0;
      end else begin
         i1_q  <= i1_d;
         i2_q  <= i2_d;
         bit_q <= bit_d;
      end
   end

   assign bit_o = bit_q;

endmodule

// File: rtl/dsm_bitstream_tx.sv
// Frame-held sample buffering with load/ready handshake
// feeding a second-order delta-sigma modulator.
module dsm_bitstream_tx
   import dsm_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load,
   output logic             ready,
   output logic             bit_out,
   output logic             frame_start,
   output logic             overrun
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   sample_t          pend_q, pend_d;
   sample_t          active_q, active_d;
   logic             pend_v_q, pend_v_d;
   logic             fs_q, fs_d;
   logic             ovr_q, ovr_d;
   logic             wrap;

   assign wrap = (cnt_q == CNT_W'(OSR - 1));

   always_comb begin
      cnt_d    = cnt_q + 1'b1;
      pend_d   = pend_q;
      pend_v_d = pend_v_q;
      active_d = active_q;
      ovr_d    = ovr_q;
      fs_d     = wrap;
      if (wrap && pend_v_q) begin
         active_d = pend_q;
         pend_v_d = 1'b0;
      end
      // a load at the boundary lands in pending only
      if (load && !pend_v_q) begin
         pend_d   = data_in;
         pend_v_d = 1'b1;
      end
      if (load && pend_v_q)
         ovr_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         pend_q   <= '0;
         pend_v_q <= 1'b0;
         active_q <= sample_t'(MIDSCALE);
         fs_q     <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         pend_q   <= pend_d;
         pend_v_q <= pend_v_d;
         active_q <= active_d;
         fs_q     <= fs_d;
         ovr_q    <= ovr_d;
      end
   end

   dsm_mod2_core u_core (
      .clk      (clk),
      .rst_n    (rst_n),
      .active_i (active_q),
      .bit_o    (bit_out)
   );

   assign ready       = ~pend_v_q;
   assign frame_start = fs_q;
   assign overrun     = ovr_q;

endmodule

// File: tb/tb_dsm_bitstream_tx.sv
// Directed bench for dsm_bitstream_tx: frame ones-density,
// handshake, overrun, boundary latency and async reset.
module tb_dsm_bitstream_tx;

   localparam int N = 512;

   logic        clk;
   logic        rst_n;
   logic [11:0] data_in;
   logic        load;
   logic        ready;
   logic        bit_out;
   logic        frame_start;
   logic        overrun;

   int checks;
   int errors;
   int c;
   bit fs_en;

   typedef struct {
      logic [11:0] val;
      int          ones;
      int          tol;
   } vec_t;

   vec_t vecs[8];

   dsm_bitstream_tx dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .data_in     (data_in),
      .load        (load),
      .ready       (ready),
      .bit_out     (bit_out),
      .frame_start (frame_start),
      .overrun     (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0d required %0d", name, act, exp);
      end
   endtask

   task automatic chk_rng(input string name, input int act,
                          input int exp, input int tol);
      checks++;
      if (act < exp - tol || act > exp + tol) begin
         errors++;
         $display("FAIL %s actual %0d required %0d +/-%0d",
                  name, act, exp, tol);
      end
   endtask

   // one clock; c tracks the DUT frame counter (cnt = c % N)
   task automatic tick();
      @(negedge clk);
      c++;
      if (fs_en)
         chk($sformatf("frame_start@%0d", c), int'(frame_start),
             int'((c % N) == 0));
   endtask

   task automatic wait_cnt(input int k);
      while ((c % N) != k) tick();
   endtask

   task automatic count_frame(output int ones);
      ones = 0;
      repeat (N) begin
         tick();
         ones += int'(bit_out);
      end
   endtask

   task automatic reset_outputs_chk(input string tag);
      chk({tag, "_ready"}, int'(ready), 1);
      chk({tag, "_bit"}, int'(bit_out), 0);
      chk({tag, "_fs"}, int'(frame_start), 0);
      chk({tag, "_ovr"}, int'(overrun), 0);
   endtask

   task automatic release_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      c     = 0;
      fs_en = 1'b1;
   endtask

   task automatic load_at(input int k, input logic [11:0] v);
      wait_cnt(k);
      load    = 1'b1;
      data_in = v;
      tick();
      load    = 1'b0;
   endtask

   initial begin
      int ones;
      checks  = 0;
      errors  = 0;
      c       = 0;
      fs_en   = 1'b0;
      load    = 1'b0;
      data_in = '0;
      rst_n   = 1'b0;

      vecs[0] = '{12'd1024, 128, 2};
      vecs[1] = '{12'd3000, 375, 2};
      vecs[2] = '{12'd256,  32,  2};
      vecs[3] = '{12'd3832, 479, 2};
      vecs[4] = '{12'd600,  75,  2};
      vecs[5] = '{12'd2048, 256, 2};
      vecs[6] = '{12'd0,    0,   5};
      vecs[7] = '{12'd4095, 512, 5};

      repeat (2) @(negedge clk);
      #1;
      reset_outputs_chk("rst0");
      release_reset();

      // two idle frames at midscale
      ones = int'(bit_out);
      repeat (N - 1) begin
         tick();
         ones += int'(bit_out);
      end
      chk_rng("idle_frame0", ones, 256, 2);
      count_frame(ones);
      chk_rng("idle_frame1", ones, 256, 2);
      chk("idle_ready", int'(ready), 1);
      chk("idle_ovr", int'(overrun), 0);

      foreach (vecs[i]) begin
         load_at(10, vecs[i].val);
         chk($sformatf("v%0d_ready_lo", i), int'(ready), 0);
         wait_cnt(0);
         chk($sformatf("v%0d_ready_hi", i), int'(ready), 1);
         count_frame(ones);
         count_frame(ones);
         chk_rng($sformatf("v%0d_ones_%0d", i, vecs[i].val),
                 ones, vecs[i].ones, vecs[i].tol);
      end
      chk("table_ovr", int'(overrun), 0);

      // overrun: second load while pending is full is dropped
      load_at(10, 12'd3000);
      load_at(20, 12'd500);
      chk("ovr_set", int'(overrun), 1);
      chk("ovr_ready", int'(ready), 0);
      wait_cnt(0);
      count_frame(ones);
      count_frame(ones);
      chk_rng("ovr_ones_3000", ones, 375, 2);
      chk("ovr_sticky", int'(overrun), 1);

      // load on the boundary edge: old value repeats one more frame
      load_at(N - 1, 12'd1024);
      chk("bnd_ready_lo", int'(ready), 0);
      count_frame(ones);
      chk_rng("bnd_old_frame", ones, 375, 2);
      chk("bnd_ready_hi", int'(ready), 1);
      count_frame(ones);
      count_frame(ones);
      chk_rng("bnd_new_frame", ones, 128, 2);
      chk("bnd_ovr_sticky", int'(overrun), 1);

      // async reset mid-frame with a pending sample
      load_at(10, 12'd3500);
      wait_cnt(100);
      chk("mid_pending", int'(ready), 0);
      fs_en = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      reset_outputs_chk("rst_mid");
      release_reset();
      ones = int'(bit_out);
      repeat (N - 1) begin
         tick();
         ones += int'(bit_out);
      end
      chk_rng("post_rst_frame", ones, 256, 2);
      chk("post_rst_ovr", int'(overrun), 0);
      tick();
      chk("post_rst_ready", int'(ready), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dsm_bitstream_tx.md
Name: dsm_bitstream_tx

Overview:
- Transmit-side counterpart of the decimating bitstream filter.
- Accepts 12-bit unsigned samples through a one-deep load/ready handshake and holds each sample for one OSR-cycle frame (zero-order hold).
- Converts the held sample into a 1-bit second-order delta-sigma bitstream.
- The stream's ones density encodes sample/4096, so the existing decimation filter (OSR 512, 2nd-order, >>6) reconstructs the sample in loopback.

Parameters:
- WIDTH, 12, sample width; full scale is 2^WIDTH.
- OSR, 512, bits per frame; must be a power of two, >= 4.
- ACC_W, 16, signed integrator width.

Ports:
- clk  input  1  sole clock.
- rst_n  input  1  asynchronous active-low reset.
- data_in  input  WIDTH  unsigned sample.
- load  input  1  sample strobe, accepted when ready=1.
- ready  output  1  pending buffer empty.
- bit_out  output  1  registered modulator bitstream.
- frame_start  output  1  one-cycle pulse on the first bit period of each frame after the first.
- overrun  output  1  sticky flag: load seen while ready=0.

Behaviour:
- Reset (asynchronous, while rst_n=0):
  - cnt=0, pending_valid=0, pending=0, active=MIDSCALE (2^(WIDTH-1)).
  - i1=i2=0, bit_out=0, ready=1, frame_start=0, overrun=0.
  - Reset mid-frame discards the held and pending samples and restarts framing at cnt=0.
- Frame counter:
  - cnt is log2(OSR) bits, increments every cycle and wraps OSR-1 -> 0.
  - frame_start <= (cnt==OSR-1), so it is high exactly in the cycles where cnt==0 following a wrap.
  - No frame_start is issued for the first frame after reset.
- Handshake:
  - ready = !pending_valid (combinational from the register).
  - load && ready at an edge: pending <= data_in, pending_valid <= 1.
  - load && !ready: the sample is dropped, overrun <= 1; overrun clears only on reset.
- Frame boundary (edge where cnt==OSR-1):
  - If pending_valid: active <= pending and pending_valid <= 0, so ready=1 in the cycle with cnt==0.
  - Otherwise active is unchanged (the last sample repeats).
  - A load accepted on this same edge (pending was empty) goes to pending only. It becomes active one frame later; there is no bypass.
  - A new active value drives the modulator from the cnt==0 cycle onward.
- Modulator, evaluated every cycle:
  - u = signed(active) - MIDSCALE, range -2048..2047.
  - fb = bit_out ? +MIDSCALE : -MIDSCALE.
  - i1' = sat(i1 + u - fb); i2' = sat(i2 + i1' - fb).
  - bit_out <= (i2' >= 0).
  - sat clamps to the ACC_W signed range. Arithmetic is performed in ACC_W+2 bits before clamping, so no wrap-around ever occurs.
- Accuracy requirement:
  - For a steady sample x in [256, 3839], the ones count over any OSR-bit window equals x*OSR/4096 within +/-2.
  - Extremes 0 and 4095 must stay bounded (saturation) and give density within 1% of x/4096.
- Latency: a sample loaded with pending empty during frame k becomes active at the start of frame k+1.

Decomposition:
- Package dsm_pkg:
  - WIDTH, OSR, CNT_W=$clog2(OSR), ACC_W, MIDSCALE.
  - Typedefs sample_t (logic [WIDTH-1:0]) and acc_t (logic signed [ACC_W-1:0]).
  - Function sat_acc.
- Sub-module dsm_mod2_core:
  - Holds the integrators and bit_out register; inputs active sample, clk, rst_n.
  - The top module keeps cnt, pending/active buffering, handshake, frame_start and overrun.

Test Plan:
- Reset, no loads, run 2 frames -> active=2048; bit_out ones count per 512-bit frame = 256 +/-2; ready=1; frame_start high at cycles 512 and 1024 after reset release; overrun=0.
- Load 1024 at cnt=10 -> ready falls the next cycle and rises in the cnt==0 cycle; the following frame has 128 +/-2 ones.
- Load 3000, then load 500 while ready=0 -> overrun=1 and stays 1; 500 never appears; frames carry 3000*512/4096 = 375 +/-2 ones.
- Load exactly at cnt=OSR-1 with pending empty -> value is active only after the next boundary, i.e. one extra frame of the previous value.
- Assert rst_n=0 mid-frame with pending_valid=1 -> all outputs return to reset values immediately; after release the first frame carries 256 +/-2 ones.
- Loopback into digital_filter with its reset aligned to frame_start; feed 100, 2048, 3900, 0, 4095, each held 3 frames -> from the second frame of each value, data_out is within +/-8 of the input (extremes within +/-41); no overrun.
